encoder_8b10b_lanes: RTL

//  Multi-lane 8b/10b encoder: LANES bytes per beat, running disparity (RD) chained lane-to-lane and beat-to-beat.

---
 rtl/encoder_8b10b_lanes.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/encoder_8b10b_lanes.sv
// ---------------------------------------------------------------------------
// encoder_8b10b_lanes
//   Multi-lane 8b/10b encoder. Encodes LANES bytes per beat and chains the
//   running disparity (RD) from lane to lane inside a beat and from beat to
//   beat. Lane 0 is first in time. There is one registered output stage with
//   valid/ready handshakes on both sides.
//
// Parameters
//   LANES       bytes per beat (1..8)
//   DISP_INIT   RD after reset (0 = RD-, 1 = RD+)
//   BIT_REVERSE 0: code bit a at bit 9 of each lane, j at bit 0
//               1: code bit a at bit 0 of each lane, j at bit 9
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   en               global enable; low freezes all state
//   disp_load/val    one-cycle RD load; wins over the beat RD update
//   in_valid/ready   input handshake
//   din, kin         lane i byte at [8i+7:8i] (HGFEDCBA), lane i K flag
//   out_valid/ready  output handshake
//   dout             lane i code group at [10i+9:10i]
//   disp             RD after the last lane of the beat on dout
//   kin_err          lane i requested an illegal K code
// ---------------------------------------------------------------------------
module encoder_8b10b_lanes #(
  parameter int LANES       = 2,
  parameter bit DISP_INIT   = 1'b0,
  parameter bit BIT_REVERSE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  disp_load,
  input  logic                  disp_val,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*LANES-1:0]    din,
  input  logic [LANES-1:0]      kin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [10*LANES-1:0]   dout,
  output logic                  disp,
  output logic [LANES-1:0]      kin_err
);

  generate
    if (LANES < 1 || LANES > 8) begin : g_bad_lanes
      $error("encoder_8b10b_lanes: LANES must be in 1..8");
    end
  endgenerate

  // 5b/6b data codes (abcdei, a in MSB) as used at RD-.
  function automatic logic [5:0] data6(input logic [4:0] x);
    logic [5:0] c;
    case (x)
      5'd0:    c = 6'b100111;
      5'd1:    c = 6'b011101;
      5'd2:    c = 6'b101101;
      5'd3:    c = 6'b110001;
      5'd4:    c = 6'b110101;
      5'd5:    c = 6'b101001;
      5'd6:    c = 6'b011001;
      5'd7:    c = 6'b111000;
      5'd8:    c = 6'b111001;
      5'd9:    c = 6'b100101;
      5'd10:   c = 6'b010101;
      5'd11:   c = 6'b110100;
      5'd12:   c = 6'b001101;
      5'd13:   c = 6'b101100;
      5'd14:   c = 6'b011100;
      5'd15:   c = 6'b010111;
      5'd16:   c = 6'b011011;
      5'd17:   c = 6'b100011;
      5'd18:   c = 6'b010011;
      5'd19:   c = 6'b110010;
      5'd20:   c = 6'b001011;
      5'd21:   c = 6'b101010;
      5'd22:   c = 6'b011010;
      5'd23:   c = 6'b111010;
      5'd24:   c = 6'b110011;
      5'd25:   c = 6'b100110;
      5'd26:   c = 6'b010110;
      5'd27:   c = 6'b110110;
      5'd28:   c = 6'b001110;
      5'd29:   c = 6'b101110;
      5'd30:   c = 6'b011110;
      default: c = 6'b101011;
    endcase
    return c;
  endfunction

  // 3b/4b data codes (fghj) as used when the RD after the 6b block is RD-.
  function automatic logic [3:0] data4(input logic [2:0] y, input logic alt7);
    logic [3:0] c;
    case (y)
      3'd0:    c = 4'b1011;
      3'd1:    c = 4'b1001;
      3'd2:    c = 4'b0101;
      3'd3:    c = 4'b1100;
      3'd4:    c = 4'b1101;
      3'd5:    c = 4'b1010;
      3'd6:    c = 4'b0110;
      default: c = alt7 ? 4'b0111 : 4'b1110;
    endcase
    return c;
  endfunction

  // 3b/4b codes for K28.y when the RD after the 6b block is RD-. Unlike the
  // data table, the balanced entries are also complemented at RD+ so that
  // K28.1/5/7 carry the comma.
  function automatic logic [3:0] k28_4(input logic [2:0] y);
    logic [3:0] c;
    case (y)
      3'd0:    c = 4'b1011;
      3'd1:    c = 4'b0110;
      3'd2:    c = 4'b1010;
      3'd3:    c = 4'b1100;
      3'd4:    c = 4'b1101;
      3'd5:    c = 4'b0101;
      3'd6:    c = 4'b1001;
      default: c = 4'b0111;
    endcase
    return c;
  endfunction

  // Returns {kin_err, rd_out, code[9:0]} for one lane.
  function automatic logic [11:0] encode_lane(input logic rd_in,
                                              input logic [7:0] d,
                                              input logic k);
    logic [4:0] x;
    logic [2:0] y;
    logic       k28, kx7, k_ok, use_k28;
    logic       flip6, flip4, rd_mid, rd_out, alt7;
    logic [5:0] c6;
    logic [3:0] c4;
    logic [9:0] code, ordered;
    x       = d[4:0];
    y       = d[7:5];
    k28     = (x == 5'd28);
    kx7     = (y == 3'd7) && ((x == 5'd23) || (x == 5'd27) ||
                              (x == 5'd29) || (x == 5'd30));
    k_ok    = k && (k28 || kx7);
    use_k28 = k_ok && k28;

    if (use_k28) begin
      c6    = 6'b001111;
      flip6 = 1'b1;
    end else begin
      c6    = data6(x);
      flip6 = ($countones(c6) != 3);
    end
    // D7 is balanced but still has a distinct RD+ form.
    if (rd_in && (flip6 || (x == 5'd7)))
      c6 = ~c6;
    rd_mid = rd_in ^ flip6;

    // A7 avoids a run of five equal bits across the 6b/4b boundary; K.x.7
    // always uses the A7 form.
    alt7 = k_ok ||
           (!rd_mid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
           ( rd_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));

    c4    = use_k28 ? k28_4(y) : data4(y, alt7);
    flip4 = (y == 3'd0) || (y == 3'd4) || (y == 3'd7);
    if (rd_mid && (flip4 || (y == 3'd3) || use_k28))
      c4 = ~c4;
    rd_out = rd_mid ^ flip4;

    code = {c6, c4};
    if (BIT_REVERSE) begin
      for (int j = 0; j < 10; j++)
        ordered[j] = code[9-j];
    end else begin
      ordered = code;
    end
    return {k && !k_ok, rd_out, ordered};
  endfunction

  logic                 rd;
  logic                 accept;
  logic                 enc_rd;
  logic [10*LANES-1:0]  enc_code;
  logic [LANES-1:0]     enc_err;

  assign in_ready = en & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  // RD ripples through the lanes within a single combinational pass.
  always_comb begin : encode_chain
    logic        rd_cur;
    logic [11:0] res;
    rd_cur   = rd;
    res      = '0;
    enc_code = '0;
    enc_err  = '0;
    for (int i = 0; i < LANES; i++) begin
      res                  = encode_lane(rd_cur, din[8*i +: 8], kin[i]);
      enc_code[10*i +: 10] = res[9:0];
      enc_err[i]           = res[11];
      rd_cur               = res[10];
    end
    enc_rd = rd_cur;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      dout      <= '0;
      disp      <= DISP_INIT;
      kin_err   <= '0;
      rd        <= DISP_INIT;
    end else if (en) begin
      if (accept) begin
        out_valid <= 1'b1;
        dout      <= enc_code;
        disp      <= enc_rd;
        kin_err   <= enc_err;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // The load wins; the beat accepted this cycle already used the old RD.
      if (disp_load)
        rd <= disp_val;
      else if (accept)
        rd <= enc_rd;
    end
  end

endmodule
